seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed hex display driver for multi-digit 7-segment displays. It captures a packed NUM_DIGITS-nibble value plus per-digit decimal points and scans one digit at a time with a programmable refresh rate. It adds three features: a guard interval against ghosting, optional leading-zero blanking, and tear-free frame-synchronous updates. It sits between the arithmetic datapath (adder, counters) and the board's shared segment/anode pins.

---
 rtl/seg7_scan_driver.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed hex driver for multi-digit 7-segment displays.
// One digit is lit per slot of CLK_DIV cycles. The first GUARD cycles of each
// slot keep all anodes dark to avoid ghosting. Leading zeros can be blanked.
// New values are staged in a shadow register and only reach the display at a
// frame boundary, so a frame is never torn between an old value and a new one.
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_DIV       = 50000,
    parameter int GUARD         = 2,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    // Everything is built in active-low form, then XORed with these masks.
    localparam logic [6:0]            SEG_POL = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic                  DP_POL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '0 : '1;

    localparam logic [6:0]            SEG_OFF = 7'h7F ^ SEG_POL;
    localparam logic                  DP_OFF  = 1'b1 ^ DP_POL;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{1'b1}} ^ AN_POL;

    logic [PW-1:0]         presc_q, presc_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [VW-1:0]         shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  tick;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  show_anode;
    logic [6:0]            seg_al;
    logic [NUM_DIGITS-1:0] an_al;

    // Hex nibble to active-low segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'b1000000;
            4'h1:    code = 7'b1111001;
            4'h2:    code = 7'b0100100;
            4'h3:    code = 7'b0110000;
            4'h4:    code = 7'b0011001;
            4'h5:    code = 7'b0010010;
            4'h6:    code = 7'b0000010;
            4'h7:    code = 7'b1111000;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0010000;
            4'hA:    code = 7'b0001000;
            4'hB:    code = 7'b0000011;
            4'hC:    code = 7'b1000110;
            4'hD:    code = 7'b0100001;
            4'hE:    code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (digit_q == DIGIT_LAST);

    // Prescaler, digit index, shadow capture and frame-synchronous display reload.
    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        digit_d      = digit_q;
        if (tick) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
        shadow_val_d = load ? value_in : shadow_val_q;
        shadow_dp_d  = load ? dp_in    : shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (boundary) begin
            disp_val_d = load ? value_in : shadow_val_q;
            disp_dp_d  = load ? dp_in    : shadow_dp_q;
        end
        frame_tick_d = boundary;
    end

    // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        blank_vec   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above  = zeros_above && (disp_val_q[4*i +: 4] == 4'h0);
            blank_vec[i] = zeros_above && (BLANK_LEADING != 0) && (i != 0);
        end
    end

    // Pick the nibble, dp and blank flag of the digit currently being scanned.
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                cur_nibble = disp_val_q[4*i +: 4];
                cur_dp     = disp_dp_q[i];
                cur_blank  = blank_vec[i];
            end
        end
    end

    // Build the next segment/dp/anode outputs; anodes stay dark during the guard window.
    always_comb begin
        show_anode = (presc_q >= GUARD_END) && (!cur_blank || cur_dp);
        seg_al     = cur_blank ? 7'h7F : hex_to_seg(cur_nibble);
        an_al      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show_anode && (digit_q == DW'(i))) begin
                an_al[i] = 1'b0;
            end
        end
        seg_d = seg_al ^ SEG_POL;
        dp_d  = ~cur_dp ^ DP_POL;
        an_d  = an_al ^ AN_POL;
    end

    // State and output registers; reset blanks the display and drops any staged value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            digit_q      <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver.
// Three instances share one stimulus stream: active-low with blanking,
// active-high without blanking, and a single-digit build. A timeline model
// derives every expected output from the cycle count since reset.
module tb_seg7_scan_driver;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic [3:0]  an_a, an_b;
    logic [0:0]  an_c;
    logic        ft_a, ft_b, ft_c;

    int          checks = 0;
    int          errors = 0;
    bit          checks_on = 0;

    int          t;
    int unsigned sh_val, sh_dp;
    int unsigned disp_a_val, disp_a_dp, disp_b_val, disp_b_dp, disp_c_val, disp_c_dp;
    logic [16:0] exp_a, exp_b, exp_c;

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .GUARD(1), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
        .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a), .frame_tick(ft_a)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .GUARD(1), .ACTIVE_LOW(0), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
        .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b), .frame_tick(ft_b)
    );

    seg7_scan_driver #(.NUM_DIGITS(1), .CLK_DIV(3), .GUARD(2), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_c (
        .clk(clk), .rst(rst), .value_in(value_in[3:0]), .dp_in(dp_in[0:0]), .load(load),
        .seg_out(seg_c), .dp_out(dp_c), .an_out(an_c), .frame_tick(ft_c)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {frame_tick, an[7:0], dp, seg[6:0]} at cycle t since reset release.
    function automatic logic [16:0] modelOutput(int tc, int unsigned disp, int unsigned dpv,
                                                int n, int cd, int g, bit al, bit bl);
        int          presc;
        int          dig;
        int unsigned upper;
        bit          dpb;
        bit          blank;
        logic [6:0]  seg;
        logic [7:0]  an_mask;
        logic [7:0]  an;
        logic        dpo;
        logic        ft;
        presc   = tc % cd;
        dig     = (tc / cd) % n;
        upper   = disp >> (4 * dig);
        dpb     = ((dpv >> dig) & 1) != 0;
        blank   = bl && (dig != 0) && (upper == 0);
        seg     = blank ? 7'h7F : SEG_TABLE[upper & 15];
        an_mask = 8'((1 << n) - 1);
        an      = an_mask;
        if ((presc >= g) && (!blank || dpb)) an = an_mask & ~8'(1 << dig);
        dpo     = !dpb;
        ft      = (tc % (n * cd)) == (n * cd - 1);
        if (!al) begin
            seg = ~seg;
            dpo = ~dpo;
            an  = an_mask & ~an;
        end
        return {ft, an, dpo, seg};
    endfunction

    function automatic logic [16:0] offOutput(int n, bit al);
        return al ? {1'b0, 8'((1 << n) - 1), 1'b1, 7'h7F} : 17'h0;
    endfunction

    function automatic bit isBoundary(int tc, int n, int cd);
        return (tc % (n * cd)) == (n * cd - 1);
    endfunction

    // Reference timeline: expected outputs for this cycle, then shadow/display bookkeeping.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t          = 0;
            sh_val     = 0;
            sh_dp      = 0;
            disp_a_val = 0; disp_a_dp = 0;
            disp_b_val = 0; disp_b_dp = 0;
            disp_c_val = 0; disp_c_dp = 0;
            exp_a      = offOutput(4, 1'b1);
            exp_b      = offOutput(4, 1'b0);
            exp_c      = offOutput(1, 1'b1);
        end else begin
            exp_a = modelOutput(t, disp_a_val, disp_a_dp, 4, 4, 1, 1'b1, 1'b1);
            exp_b = modelOutput(t, disp_b_val, disp_b_dp, 4, 4, 1, 1'b0, 1'b0);
            exp_c = modelOutput(t, disp_c_val, disp_c_dp, 1, 3, 2, 1'b1, 1'b1);
            if (isBoundary(t, 4, 4)) begin
                disp_a_val = load ? value_in : sh_val;
                disp_a_dp  = load ? dp_in : sh_dp;
                disp_b_val = disp_a_val;
                disp_b_dp  = disp_a_dp;
            end
            if (isBoundary(t, 1, 3)) begin
                disp_c_val = (load ? value_in : sh_val) & 32'hF;
                disp_c_dp  = (load ? dp_in : sh_dp) & 32'h1;
            end
            if (load) begin
                sh_val = value_in;
                sh_dp  = dp_in;
            end
            t++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, want, $time);
        end
    endtask

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (checks_on) begin
            checkOutput("a_seg", 32'(seg_a), 32'(exp_a[6:0]));
            checkOutput("a_dp",  32'(dp_a),  32'(exp_a[7]));
            checkOutput("a_an",  32'(an_a),  32'(exp_a[15:8]));
            checkOutput("a_ft",  32'(ft_a),  32'(exp_a[16]));
            checkOutput("b_seg", 32'(seg_b), 32'(exp_b[6:0]));
            checkOutput("b_dp",  32'(dp_b),  32'(exp_b[7]));
            checkOutput("b_an",  32'(an_b),  32'(exp_b[15:8]));
            checkOutput("b_ft",  32'(ft_b),  32'(exp_b[16]));
            checkOutput("c_seg", 32'(seg_c), 32'(exp_c[6:0]));
            checkOutput("c_dp",  32'(dp_c),  32'(exp_c[7]));
            checkOutput("c_an",  32'(an_c),  32'(exp_c[15:8]));
            checkOutput("c_ft",  32'(ft_c),  32'(exp_c[16]));
        end
    end

    // Drive one cycle of inputs, then drop load just after the edge.
    task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] d);
        load     = ld;
        value_in = v;
        dp_in    = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom), 4'($urandom));
    endtask

    // Advance idle cycles until the next edge will use timeline cycle phase ph of a 16-cycle frame.
    task automatic idleUntilPhase(input int ph);
        for (int k = 0; k < 40 && (t % 16) != ph; k++) idleCycles(1);
        if ((t % 16) != ph) checkOutput("sync_phase", 32'(t % 16), 32'(ph));
    endtask

    // Stop on the falling edge after the DUT has produced the outputs for cycle s.
    task automatic waitState(input int s);
        for (int k = 0; k < 200 && t != s + 1; k++) @(negedge clk);
        if (t != s + 1) checkOutput("wait_state", 32'(t), 32'(s + 1));
    endtask

    task automatic resetChecks();
        checkOutput("rst_a_seg", 32'(seg_a), 32'h7F);
        checkOutput("rst_a_dp",  32'(dp_a),  32'h1);
        checkOutput("rst_a_an",  32'(an_a),  32'hF);
        checkOutput("rst_a_ft",  32'(ft_a),  32'h0);
        checkOutput("rst_b_seg", 32'(seg_b), 32'h00);
        checkOutput("rst_b_dp",  32'(dp_b),  32'h0);
        checkOutput("rst_b_an",  32'(an_b),  32'h0);
        checkOutput("rst_b_ft",  32'(ft_b),  32'h0);
        checkOutput("rst_c_seg", 32'(seg_c), 32'h7F);
        checkOutput("rst_c_dp",  32'(dp_c),  32'h1);
        checkOutput("rst_c_an",  32'(an_c),  32'h1);
        checkOutput("rst_c_ft",  32'(ft_c),  32'h0);
    endtask

    // Reset asserted between edges; outputs must go dark before the next edge.
    task automatic midSlotReset();
        #2;
        rst  = 1'b1;
        load = 1'b0;
        #1;
        resetChecks();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] scan_seg_b [4];
        logic [15:0] masks [4];
        scan_seg_b = '{7'b1110001, 7'b1110111, 7'b1011011, 7'b0000110};
        masks      = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};

        rst      = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        #2 rst   = 1'b1;
        #1 checks_on = 1'b1;
        resetChecks();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Scan order: 12AF loaded in cycle 0 becomes visible after the cycle-15 boundary.
        applyStimulus(1'b1, 16'h12AF, 4'h0);
        waitState(15);
        checkOutput("scan_b_ft", 32'(ft_b), 32'h1);
        waitState(16);
        checkOutput("scan_b_guard_an", 32'(an_b), 32'h0);
        for (int d = 0; d < 4; d++) begin
            waitState(17 + 4 * d);
            checkOutput("scan_b_an",  32'(an_b),  32'(1 << d));
            checkOutput("scan_b_seg", 32'(seg_b), 32'(scan_seg_b[d]));
            if (d == 0) begin
                checkOutput("scan_a_an",  32'(an_a),  32'hE);
                checkOutput("scan_a_seg", 32'(seg_a), 32'h0E);
            end
        end
        #1;

        // Tear-free update: a mid-frame load waits for the boundary.
        applyStimulus(1'b1, 16'h1111, 4'h0);
        idleCycles(5);
        applyStimulus(1'b1, 16'h2222, 4'h0);
        idleCycles(40);

        // Leading-zero blanking, including a blank digit kept alive by its dp.
        applyStimulus(1'b1, 16'h0050, 4'h0);
        idleCycles(40);
        applyStimulus(1'b1, 16'h0000, 4'b1000);
        idleCycles(40);

        // Load exactly on the boundary cycle takes effect in the frame that follows.
        idleUntilPhase(15);
        applyStimulus(1'b1, 16'h5A3C, 4'b0101);
        idleCycles(40);

        // Back-to-back loads: only the last survives.
        idleUntilPhase(4);
        applyStimulus(1'b1, 16'hAAAA, 4'h0);
        applyStimulus(1'b1, 16'hBBBB, 4'h0);
        applyStimulus(1'b1, 16'hCCCC, 4'h0);
        idleCycles(40);

        // Reset mid-frame with a load still pending in the shadow.
        idleUntilPhase(9);
        applyStimulus(1'b1, 16'h7777, 4'hF);
        midSlotReset();
        idleCycles(40);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 2400; i++) begin
            if (i == 800 || i == 1600) begin
                midSlotReset();
            end else if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, 16'($urandom) & masks[$urandom_range(0, 3)], 4'($urandom));
            end else begin
                idleCycles(1);
            end
        end

        @(negedge clk);
        checks_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
